// File: rtl/alu_pkg.sv
// Shared ALU encodings: 4-bit ALU function codes, the 2-bit ALUOp values
// produced by the main decoder, and the R-type funct field values.
package alu_pkg;

  // ALU function codes. Bit 3 selects B inversion (subtract / compare).
  // Codes with F[2:0] = 100 or 101 are shifts.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct to ALU function-code decoder.
// Ports:
//   i_aluop   ALUOp from the main decoder
//   i_funct   R-type funct field
//   o_alu_f   4-bit ALU function code
//   o_illegal high for an R-type funct this ALU does not implement
module alu_decoder
  import alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_f,
  output logic       o_illegal
);

  always_comb begin
    o_alu_f   = ALU_ADD;
    o_illegal = 1'b0;
    case (i_aluop)
      ALUOP_ADD: o_alu_f = ALU_ADD;
      ALUOP_SUB: o_alu_f = ALU_SUB;
      ALUOP_ORI: o_alu_f = ALU_OR;
      default: begin
        case (i_funct)
          FUNCT_ADD: o_alu_f = ALU_ADD;
          FUNCT_SUB: o_alu_f = ALU_SUB;
          FUNCT_AND: o_alu_f = ALU_AND;
          FUNCT_OR:  o_alu_f = ALU_OR;
          FUNCT_SLT: o_alu_f = ALU_SLT;
          FUNCT_SLL: o_alu_f = ALU_SLL;
          FUNCT_SRL: o_alu_f = ALU_SRL;
          default: begin
            // Unsupported funct still executes as an add so the pipe keeps
            // moving; the flag lets a trap unit decide what to do.
            o_alu_f   = ALU_ADD;
            o_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand preparation.
// Captures decoded fields from ID, forwards MEM/WB results onto rs/rt,
// decodes the ALU function and drives the ALU operands directly.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   stall, flush          hold / insert bubble (flush wins over stall)
//   id_*                  decoded instruction fields and control bits
//   mem_*, wb_*           later-stage writeback info for forwarding
//   alu_a/b/f/shamt       ALU operands, function code, shift amount
//   ex_writedata          forwarded rt value for stores
//   ex_writereg           selected destination register
//   ex_rs, ex_rt          registered source indices for the hazard unit
//   ex_regwrite/memtoreg/memwrite  registered downstream control
//   ex_illegal            unsupported R-type funct in EX
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_signimm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [5:0]    id_funct,
  input  logic [1:0]    id_aluop,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memtoreg,
  input  logic          id_memwrite,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] mem_writereg,
  input  logic [DW-1:0] mem_aluout,
  input  logic          wb_regwrite,
  input  logic [RW-1:0] wb_writereg,
  input  logic [DW-1:0] wb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_f,
  output logic [4:0]    alu_shamt,
  output logic [DW-1:0] ex_writedata,
  output logic [RW-1:0] ex_writereg,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic          ex_memwrite,
  output logic          ex_illegal
);

  logic [DW-1:0] r_rd1, r_rd2, r_imm;
  logic [RW-1:0] r_rs, r_rt, r_rd;
  logic [4:0]    r_shamt;
  logic [5:0]    r_funct;
  logic [1:0]    r_aluop;
  logic          r_alusrc, r_regdst, r_regwrite, r_memtoreg, r_memwrite;

  // Priority: reset > flush > stall > load. A cleared register is a NOP.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_shamt    <= '0;
      r_funct    <= '0;
      r_aluop    <= '0;
      r_alusrc   <= 1'b0;
      r_regdst   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (!stall) begin
      r_rd1      <= id_rd1;
      r_rd2      <= id_rd2;
      r_imm      <= id_signimm;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_shamt    <= id_shamt;
      r_funct    <= id_funct;
      r_aluop    <= id_aluop;
      r_alusrc   <= id_alusrc;
      r_regdst   <= id_regdst;
      r_regwrite <= id_regwrite;
      r_memtoreg <= id_memtoreg;
      r_memwrite <= id_memwrite;
    end
  end

  // Forwarding: MEM is younger than WB, so it wins; r0 is hardwired zero
  // and never forwarded.
  logic [DW-1:0] w_fwd_a, w_fwd_b;

  always_comb begin
    w_fwd_a = r_rd1;
    if (mem_regwrite && (mem_writereg != '0) && (mem_writereg == r_rs))
      w_fwd_a = mem_aluout;
    else if (wb_regwrite && (wb_writereg != '0) && (wb_writereg == r_rs))
      w_fwd_a = wb_result;
  end

  always_comb begin
    w_fwd_b = r_rd2;
    if (mem_regwrite && (mem_writereg != '0) && (mem_writereg == r_rt))
      w_fwd_b = mem_aluout;
    else if (wb_regwrite && (wb_writereg != '0) && (wb_writereg == r_rt))
      w_fwd_b = wb_result;
  end

  logic [3:0] w_alu_f;
  logic       w_illegal;

  alu_decoder u_alu_decoder (
    .i_aluop   (r_aluop),
    .i_funct   (r_funct),
    .o_alu_f   (w_alu_f),
    .o_illegal (w_illegal)
  );

  // ori uses a zero-extended immediate; everything else the sign-extended one.
  logic [DW-1:0] w_imm;
  logic          w_is_shift;

  assign w_imm      = (r_aluop == ALUOP_ORI) ? {{(DW-16){1'b0}}, r_imm[15:0]} : r_imm;
  assign w_is_shift = (w_alu_f[2:1] == 2'b10);

  // The ALU shifts its A+B sum, so zeroing A makes a shift act on rt alone.
  always_comb begin
    alu_a = w_fwd_a;
    alu_b = r_alusrc ? w_imm : w_fwd_b;
    if (w_is_shift) begin
      alu_a = '0;
      alu_b = w_fwd_b;
    end
  end

  assign alu_f        = w_alu_f;
  assign alu_shamt    = r_shamt;
  assign ex_writedata = w_fwd_b;
  assign ex_writereg  = r_regdst ? r_rd : r_rt;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_regwrite  = r_regwrite;
  assign ex_memtoreg  = r_memtoreg;
  assign ex_memwrite  = r_memwrite;
  assign ex_illegal   = w_illegal;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand preparation.
- Captures decoded instruction fields from ID and applies MEM/WB forwarding to the register operands.
- Translates ALUOp/funct into the 4-bit ALU function code, then drives A, B, F and shamt directly into the ALU.
- Also carries destination-register and downstream control bits to the EX/MEM register.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold register contents this cycle
flush  in  1  insert bubble this cycle
id_rd1  in  DW  register-file read data for rs
id_rd2  in  DW  register-file read data for rt
id_signimm  in  DW  sign-extended immediate
id_rs, id_rt, id_rd  in  RW  register indices
id_shamt  in  5  shift amount field
id_funct  in  6  R-type funct field
id_aluop  in  2  00 add, 01 sub, 10 R-type, 11 ori
id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite  in  1 each  control bits
mem_regwrite  in  1  EX/MEM writes a register
mem_writereg  in  RW  EX/MEM destination
mem_aluout  in  DW  EX/MEM result
wb_regwrite  in  1  MEM/WB writes a register
wb_writereg  in  RW  MEM/WB destination
wb_result  in  DW  MEM/WB result
alu_a, alu_b  out  DW  ALU operands
alu_f  out  4  ALU function code
alu_shamt  out  5  ALU shift amount
ex_writedata  out  DW  forwarded rt value for stores
ex_writereg  out  RW  selected destination register
ex_rs, ex_rt  out  RW  registered indices, for the hazard unit
ex_regwrite, ex_memtoreg, ex_memwrite  out  1  registered control bits
ex_illegal  out  1  unsupported funct in EX

Behaviour:
- Priority at each rising clk edge: reset > flush > stall > load.
  - reset or flush: every register cleared to 0, so all control bits are 0 and the stage holds a NOP.
  - stall: all registers keep their value.
  - otherwise: registers load the id_* inputs.
- Latency: id_* fields appear at outputs one cycle after load.
- Forwarding is combinational on registered rs/rt against the current mem_*/wb_* inputs.
  - Per operand: if mem_regwrite, mem_writereg != 0 and it matches the index, use mem_aluout.
  - Else if wb_regwrite, wb_writereg != 0 and it matches the index, use wb_result.
  - Else use the registered rd1/rd2.
  - MEM has priority over WB; register 0 is never forwarded.
- Forwarded rt drives ex_writedata regardless of alusrc.
- ex_writereg = regdst ? rd : rt, computed on registered values.
- ALU function decode (combinational, from registered aluop/funct):
  - aluop 00 -> 0010
  - aluop 01 -> 1010
  - aluop 11 -> 0001
  - aluop 10, funct 100000 add -> 0010
  - aluop 10, funct 100010 sub -> 1010
  - aluop 10, funct 100100 and -> 0000
  - aluop 10, funct 100101 or -> 0001
  - aluop 10, funct 101010 slt -> 1011
  - aluop 10, funct 000000 sll -> 0100
  - aluop 10, funct 000010 srl -> 0101
  - aluop 10, any other funct -> 0010 with ex_illegal=1. ex_illegal is 0 in every other case, including bubbles.
- Operand selection:
  - alu_b = alusrc ? imm : forwarded rt.
  - For aluop 11, imm is zero-extended: {16'b0, signimm[15:0]}.
  - For shift codes (F[2:0] = 100/101), the ALU shifts its sum, so alu_a is forced to 0 and alu_b = forwarded rt. This yields rt << shamt.
  - Otherwise alu_a = forwarded rs.
- alu_shamt = registered shamt.
- A bubble presents alu_f=0010 with operands from the zeroed register. Forwarding is still evaluated, so a bubble with rs=0 gives alu_a=0.
- Simultaneous stall and flush: flush wins.
- Reset mid-stall: clears the stage; stall is ignored that edge.

Decomposition:
- Shared package alu_pkg:
  - ALU function constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL.
  - ALUOp encodings.
  - funct constants.
- One natural sub-module: alu_decoder, the combinational aluop/funct to alu_f and illegal mapping. It is reusable by a future non-pipelined variant.
- Forwarding muxes and the pipeline register stay inline.

Test Plan:
1. Load add: rd1=5, rd2=7, aluop=10, funct=100000, rs=1, rt=2, no forwarding active -> next cycle alu_a=5, alu_b=7, alu_f=0010, ex_illegal=0.
2. Forwarding priority: registered rs=3, mem_writereg=3 with mem_aluout=0x11, wb_writereg=3 with wb_result=0x22, both regwrite=1 -> alu_a=0x11. Deassert mem_regwrite -> alu_a=0x22.
3. Register 0: rs=0, rd1=0, mem_writereg=0, mem_regwrite=1, mem_aluout=0xFFFF -> alu_a=0.
4. Shift: aluop=10, funct=000000, shamt=4, rd1=9, rd2=0x3 -> alu_a=0, alu_b=3, alu_f=0100, alu_shamt=4.
5. ori zero-extend: aluop=11, alusrc=1, signimm=0xFFFF8001 -> alu_b=0x00008001, alu_f=0001.
6. Stall then flush:
   - Load sw (memwrite=1), assert stall for 2 cycles while id_* changes -> outputs unchanged.
   - Assert stall and flush together -> next cycle ex_memwrite=0, ex_regwrite=0, ex_illegal=0.
   - Then funct=111111 with aluop=10 -> ex_illegal=1, alu_f=0010.
